tone_div_ctrl: RTL
==================

Name: tone_div_ctrl

Overview:
- Controls one programmable tone divider for a synthesizer voice.
- Accepts note-on/note-off commands with divide values through a valid/ready handshake.
- Runs an (N+1)-per-half-period counter to generate a square tone.
- Applies new divide values, and stops the tone, only at half-period boundaries, so the tone never shows a runt pulse or glitch. The downstream mixer and envelope logic consume its output.

Parameters:
- WIDTH, 16, width of the divide value and internal counter.
- RST_DIV, 1, value of cur_div after reset.

Ports:
- clk  input  1  system clock; all logic on rising edge; the block uses this single clock only.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_gate  input  1  1 = note on / retune, 0 = note off.
- cmd_div  input  WIDTH  divide parameter N; half period = N+1 clk cycles.
- tone_out  output  1  square tone, period 2*(cur_div+1) cycles.
- tick  output  1  one-cycle pulse, registered, high in the cycle after each tone_out toggle edge (coincident with new tone_out value).
- active  output  1  high whenever state != IDLE.
- cur_div  output  WIDTH  divide value currently in effect.

Behaviour:
- Reset (async assert, any state, mid-note included) forces:
  - state=IDLE, tone_out=0, tick=0, active=0
  - count=0, cur_div=RST_DIV, pend_div=0
  - cmd_ready=1 as soon as rst_n is high
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready is combinational from state: 1 in IDLE and RUN, 0 in PEND and STOP.
  - cmd_* must be held stable while cmd_valid=1 and cmd_ready=0.
- Counter:
  - Runs in RUN, PEND and STOP.
  - Boundary = count==cur_div.
  - At a boundary: count<=0, tone_out<=~tone_out, tick<=1. Otherwise: count<=count+1, tick<=0.
  - count never exceeds cur_div; wrap is explicit, not by overflow.
- State IDLE:
  - tone_out=0, count held at 0.
  - Accepted gate=1: cur_div<=cmd_div, count<=0, go to RUN. The first rising tone edge occurs cmd_div+1 cycles after the accept edge.
  - Accepted gate=0: consumed with no effect.
- State RUN:
  - Accepted gate=1: pend_div<=cmd_div, go to PEND.
  - Accepted gate=0: go to STOP.
  - An accept that coincides with a boundary still toggles on that boundary with the old cur_div; the new command takes effect from the next boundary.
- State PEND:
  - At the next boundary: toggle as normal, cur_div<=pend_div, go to RUN. The following half period uses the new value.
- State STOP:
  - At a boundary with tone_out=1: toggle to 0 (tick=1), go to IDLE, count=0.
  - At a boundary with tone_out=0: toggle to 1 and remain in STOP. The note therefore always ends on a complete period.
- cmd_div=0 is legal: tone toggles every cycle, period 2 cycles, tick high every cycle.
- cmd_div=2^WIDTH-1 is legal and needs no extra counter bit.
- cur_div changes only in IDLE accept or at a PEND boundary, never mid half-period.

Test Plan:
- Reset, then gate=1 with div=3 accepted at cycle 0:
  - tone_out rises at cycle 4 and falls at cycle 8, period 8.
  - tick high in cycles 4, 8, 12.
  - active=1 from cycle 1.
- Running with div=3, gate=1 with div=1 accepted at count=1:
  - cmd_ready=0 until the next boundary.
  - That half period still lasts 4 cycles; subsequent half periods last 2.
  - cur_div changes exactly at the boundary.
- Running with div=2, gate=0 accepted while tone_out=0:
  - tone completes a high half (3 cycles) then a falling edge.
  - IDLE is reached with tone_out=0, active=0, cmd_ready=1.
- div=0 note-on:
  - tone_out alternates every cycle and tick is constantly 1.
  - gate=0 stops within 2 cycles with tone_out=0.
- Assert rst_n=0 asynchronously while in PEND with tone_out=1:
  - tone_out, tick and active go to 0 immediately; cur_div=RST_DIV.
  - After release, a gate=0 command is accepted and ignored.
- Hold cmd_valid=1 during PEND with a changing cmd_div:
  - Nothing is accepted until RUN.
  - Only the value present at the accept edge is used.

Source files
------------

// File: rtl/tone_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// tone_div_ctrl_if
// Command channel for one tone divider voice.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : slave can take a command this cycle (slave -> master)
//   cmd_gate  : 1 = note on / retune, 0 = note off
//   cmd_div   : divide parameter N, half period = N+1 clk cycles
// The master must keep cmd_* stable while cmd_valid=1 and cmd_ready=0.
// ----------------------------------------------------------------------------
interface tone_div_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_gate;
    logic [WIDTH-1:0] cmd_div;

    modport master (
        output cmd_valid,
        output cmd_gate,
        output cmd_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_gate,
        input  cmd_div,
        output cmd_ready
    );
endinterface

// File: rtl/tone_div_ctrl.sv
// ----------------------------------------------------------------------------
// tone_div_ctrl
// Programmable square-tone divider for one synthesizer voice. Note-on,
// retune and note-off commands arrive over a valid/ready channel; divide
// changes and note-off only take effect at half-period boundaries so the
// tone never shows a runt pulse.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   cmd      : command channel (slave side of tone_div_ctrl_if)
//   tone_out : square tone, period 2*(cur_div+1) cycles
//   tick     : one-cycle pulse coincident with each new tone_out value
//   active   : high whenever a note is sounding or finishing
//   cur_div  : divide value currently in effect
// ----------------------------------------------------------------------------
module tone_div_ctrl #(
    parameter int          WIDTH   = 16,
    parameter int unsigned RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_div_ctrl_if.slave   cmd,
    output logic             tone_out,
    output logic             tick,
    output logic             active,
    output logic [WIDTH-1:0] cur_div
);

    // IDLE: silent.  RUN: sounding, accepting commands.
    // PEND: retune waiting for the next boundary.
    // STOP: note-off waiting to finish a complete period.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] pend_div;
    logic             boundary;
    logic             accept;

    // Commands are only taken when no deferred action is outstanding, so a
    // pending retune or note-off can never be overwritten.
    assign cmd.cmd_ready = (state == S_IDLE) || (state == S_RUN);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign active        = (state != S_IDLE);

    // The counter wraps by comparison rather than overflow, so a divide of
    // all ones needs no extra counter bit.
    assign boundary = (count == cur_div);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement
    // order; the reset branch is in the sensitivity list because rst_n is
    // asynchronous and must clear the outputs without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tone_out <= 1'b0;
            tick     <= 1'b0;
            count    <= '0;
            cur_div  <= WIDTH'(RST_DIV);
            pend_div <= '0;
        end else if (state == S_IDLE) begin
            tone_out <= 1'b0;
            tick     <= 1'b0;
            count    <= '0;
            // A note-off while idle is consumed with no effect.
            if (accept && cmd.cmd_gate) begin
                cur_div <= cmd.cmd_div;
                state   <= S_RUN;
            end
        end else begin
            // Counter runs identically in RUN, PEND and STOP.
            if (boundary) begin
                count    <= '0;
                tone_out <= ~tone_out;
                tick     <= 1'b1;
            end else begin
                count    <= count + WIDTH'(1);
                tick     <= 1'b0;
            end

            case (state)
                S_RUN: begin
                    // An accept on a boundary still toggles with the old
                    // divide above; the command acts from the next boundary.
                    if (accept) begin
                        if (cmd.cmd_gate) begin
                            pend_div <= cmd.cmd_div;
                            state    <= S_PEND;
                        end else begin
                            state    <= S_STOP;
                        end
                    end
                end
                S_PEND: begin
                    if (boundary) begin
                        cur_div <= pend_div;
                        state   <= S_RUN;
                    end
                end
                S_STOP: begin
                    // Leave only on the falling edge so the note always ends
                    // on a complete period; a rising boundary stays here.
                    if (boundary && tone_out) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
